// File: rtl/debug_sequencer.sv
// Debug sequencer: runs or single-steps the MIPS pipeline on UART commands and,
// after every stop, streams latch snapshot, register file and data memory to UART TX.
module debug_sequencer #(
  parameter int unsigned NB_IF_ID  = 96,
  parameter int unsigned NB_ID_EX  = 160,
  parameter int unsigned NB_EX_MEM = 128,
  parameter int unsigned NB_MEM_WB = 96,
  parameter int unsigned LEN       = 32,
  parameter int unsigned CANT_REG  = 16,
  parameter int unsigned CANT_MEM  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_tx_done,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_halt,
  input  logic [NB_IF_ID-1:0]         i_if_id,
  input  logic [NB_ID_EX-1:0]         i_id_ex,
  input  logic [NB_EX_MEM-1:0]        i_ex_mem,
  input  logic [NB_MEM_WB-1:0]        i_mem_wb,
  input  logic [LEN-1:0]              i_reg_reco,
  input  logic [LEN-1:0]              i_mem_reco,
  output logic                        o_mips_clk_en,
  output logic                        o_debug_flag,
  output logic [$clog2(CANT_REG)-1:0] o_addr_reg_reco,
  output logic [$clog2(CANT_MEM)-1:0] o_addr_mem_reco,
  output logic                        o_busy
);

  localparam int unsigned NB_TOT     = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
  localparam int unsigned LAT_BYTES  = NB_TOT / 8;
  localparam int unsigned LBW        = $clog2(LAT_BYTES + 1);
  localparam int unsigned WORD_BYTES = LEN / 8;
  localparam int unsigned WBW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned ARW        = $clog2(CANT_REG);
  localparam int unsigned AMW        = $clog2(CANT_MEM);

  localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_QUIT = 8'h51;  // 'Q'

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_STEP_WAIT,
    S_STEP,
    S_SNAP,
    S_LAT_SEND,
    S_LAT_WAIT,
    S_SET_ADDR,
    S_WAIT_DATA,
    S_WORD_SEND,
    S_WORD_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [NB_TOT-1:0]   shadow_q, shadow_d;
  logic [LBW-1:0]      lat_cnt_q, lat_cnt_d;
  logic [LEN-1:0]      word_q, word_d;
  logic [WBW-1:0]      wbyte_q, wbyte_d;
  logic                mem_phase_q, mem_phase_d;
  logic                from_step_q, from_step_d;
  logic [ARW-1:0]      addr_reg_q, addr_reg_d;
  logic [AMW-1:0]      addr_mem_q, addr_mem_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                clk_en_q, clk_en_d;
  logic                debug_q, debug_d;
  logic                busy_q, busy_d;

  // Next-state and registered-output logic; every output is computed for the next cycle.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    lat_cnt_d   = lat_cnt_q;
    word_d      = word_q;
    wbyte_d     = wbyte_q;
    mem_phase_d = mem_phase_q;
    from_step_d = from_step_q;
    addr_reg_d  = addr_reg_q;
    addr_mem_d  = addr_mem_q;
    tx_data_d   = tx_data_q;
    debug_d     = debug_q;
    tx_start_d  = 1'b0;
    clk_en_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_RUN) begin
            // A pipeline already halted gets no enable cycle at all.
            state_d     = S_RUN;
            from_step_d = 1'b0;
            clk_en_d    = ~i_halt;
          end else if (i_rx_data == CMD_STEP) begin
            state_d = S_STEP_WAIT;
          end
        end
      end

      S_RUN: begin
        if (i_halt) begin
          state_d = S_SNAP;
        end else begin
          clk_en_d = 1'b1;
        end
      end

      S_STEP_WAIT: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_NEXT) begin
            state_d     = S_STEP;
            clk_en_d    = 1'b1;
            from_step_d = 1'b1;
          end else if (i_rx_data == CMD_QUIT) begin
            state_d = S_IDLE;
          end
        end
      end

      S_STEP: begin
        state_d = S_SNAP;
      end

      S_SNAP: begin
        shadow_d  = {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
        lat_cnt_d = '0;
        state_d   = S_LAT_SEND;
      end

      S_LAT_SEND: begin
        tx_data_d  = shadow_q[NB_TOT-1 -: 8];
        tx_start_d = 1'b1;
        shadow_d   = shadow_q << 8;
        lat_cnt_d  = lat_cnt_q + LBW'(1);
        state_d    = S_LAT_WAIT;
      end

      S_LAT_WAIT: begin
        if (i_tx_done) begin
          if (lat_cnt_q == LBW'(LAT_BYTES)) begin
            state_d     = S_SET_ADDR;
            debug_d     = 1'b1;
            mem_phase_d = 1'b0;
          end else begin
            state_d = S_LAT_SEND;
          end
        end
      end

      S_SET_ADDR: begin
        state_d = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        word_d  = mem_phase_q ? i_mem_reco : i_reg_reco;
        wbyte_d = '0;
        state_d = S_WORD_SEND;
      end

      S_WORD_SEND: begin
        tx_data_d  = word_q[LEN-1 -: 8];
        tx_start_d = 1'b1;
        word_d     = word_q << 8;
        state_d    = S_WORD_WAIT;
      end

      S_WORD_WAIT: begin
        if (i_tx_done) begin
          if (wbyte_q != WBW'(WORD_BYTES - 1)) begin
            wbyte_d = wbyte_q + WBW'(1);
            state_d = S_WORD_SEND;
          end else if (!mem_phase_q) begin
            // Register phase: advance address, or wrap and move to memory.
            if (addr_reg_q == ARW'(CANT_REG - 1)) begin
              addr_reg_d  = '0;
              mem_phase_d = 1'b1;
            end else begin
              addr_reg_d = addr_reg_q + ARW'(1);
            end
            state_d = S_SET_ADDR;
          end else if (addr_mem_q == AMW'(CANT_MEM - 1)) begin
            // Dump complete: release collectors and return to the caller mode.
            addr_mem_d  = '0;
            mem_phase_d = 1'b0;
            debug_d     = 1'b0;
            state_d     = (from_step_q && !i_halt) ? S_STEP_WAIT : S_IDLE;
          end else begin
            addr_mem_d = addr_mem_q + AMW'(1);
            state_d    = S_SET_ADDR;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      lat_cnt_q   <= '0;
      word_q      <= '0;
      wbyte_q     <= '0;
      mem_phase_q <= 1'b0;
      from_step_q <= 1'b0;
      addr_reg_q  <= '0;
      addr_mem_q  <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      clk_en_q    <= 1'b0;
      debug_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      lat_cnt_q   <= lat_cnt_d;
      word_q      <= word_d;
      wbyte_q     <= wbyte_d;
      mem_phase_q <= mem_phase_d;
      from_step_q <= from_step_d;
      addr_reg_q  <= addr_reg_d;
      addr_mem_q  <= addr_mem_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      clk_en_q    <= clk_en_d;
      debug_q     <= debug_d;
      busy_q      <= busy_d;
    end
  end

  assign o_tx_data       = tx_data_q;
  assign o_tx_start      = tx_start_q;
  assign o_mips_clk_en   = clk_en_q;
  assign o_debug_flag    = debug_q;
  assign o_addr_reg_reco = addr_reg_q;
  assign o_addr_mem_reco = addr_mem_q;
  assign o_busy          = busy_q;

endmodule
